axi_sram_slave: RTL

// AXI4 slave responder backed by a byte-enabled word SRAM: the far end of the CPU's cache/SRAM-to-AXI bridge.

---
 rtl/axi_pkg.sv | 11 +
 rtl/axi_slave_mem.sv | 20 ++
 rtl/axi_sram_slave.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response/burst encodings, slave FSM states and response merge helper
package axi_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  // Encodings are ordered by severity, so the worst response is the larger code
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: 1R1W word RAM with per-byte write enables and a registered read port
module axi_slave_mem #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [31:0]           o_rdata,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata
);
  logic [31:0] r_mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
    for (int i = 0; i < 4; i++)
      if (i_we && i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave with independent 1-4 beat read/write bursts backed by a byte-enabled SRAM
module axi_sram_slave import axi_pkg::*; #(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000,
  parameter int          READ_LAT   = 2,
  parameter int          WAIT_W     = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam int          DL  = DEPTH_LOG2;
  localparam logic [31:0] WIN = 32'd4 << DL;
  // Offsets are kept relative to BASE_ADDR; only in-window offsets wrap around the window
  function automatic logic [31:0] next_off(input logic [31:0] off, input logic [1:0] burst);
    if (burst == BURST_FIXED) return off;
    return (off < WIN) ? ((off + 32'd4) & (WIN - 32'd1)) : off + 32'd4;
  endfunction
  rd_state_t r_rs, w_rs_nx;
  wr_state_t r_ws, w_ws_nx;
  logic [3:0]    r_rid, r_bid;
  logic [31:0]   r_roff, r_woff, w_ar_off, w_rnext, w_mem_q;
  logic [1:0]    r_rlen, r_rburst, r_rcnt, r_wlen, r_wburst, r_wcnt, r_bresp, w_wresp;
  logic          r_rsz_err, r_wsz_err, w_roow, w_woow, w_re, w_ar_hs, w_aw_hs, w_w_hs;
  logic [7:0]    r_lat, r_wait;
  logic [DL-1:0] w_ridx;
  logic          w_unused;
  assign w_unused = ^{arlen[7:2], awlen[7:2], wid};
  assign w_ar_hs  = arvalid && arready;
  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  assign w_ar_off = araddr - BASE_ADDR;
  assign w_rnext  = next_off(r_roff, r_rburst);
  assign w_roow   = r_roff >= WIN;
  assign w_woow   = r_woff >= WIN;
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rs <= R_IDLE;
      r_ws <= W_IDLE;
    end else begin
      r_rs <= w_rs_nx;
      r_ws <= w_ws_nx;
    end
  end
  always_comb begin
    w_rs_nx = r_rs;
    arready = 1'b0;
    rvalid  = 1'b0;
    if (r_rs == R_IDLE) begin
      arready = 1'b1;
      if (arvalid) w_rs_nx = (READ_LAT <= 1) ? R_DATA : R_LAT;
    end else if (r_rs == R_LAT) begin
      if (r_lat <= 8'd1) w_rs_nx = R_DATA;
    end else begin
      rvalid = 1'b1;
      if (rready && r_rcnt == r_rlen) w_rs_nx = R_IDLE;
    end
  end
  always_comb begin
    w_ws_nx = r_ws;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (r_ws == W_IDLE) begin
      awready = 1'b1;
      if (awvalid) w_ws_nx = W_DATA;
    end else if (r_ws == W_DATA) begin
      wready = r_wait == 8'd0;
      if (r_wait == 8'd0 && wvalid && r_wcnt == r_wlen) w_ws_nx = W_RESP;
    end else begin
      bvalid = 1'b1;
      if (bready) w_ws_nx = W_IDLE;
    end
  end
  // The RAM read port only advances on a beat handshake, so a stalled beat keeps its data
  assign w_ridx = (r_rs == R_IDLE) ? w_ar_off[DL+1:2] : (r_rs == R_DATA) ? w_rnext[DL+1:2] : r_roff[DL+1:2];
  assign w_re   = (r_rs == R_IDLE) ? arvalid : (r_rs == R_LAT) ? 1'b1 : rready;
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rid     <= '0;
      r_roff    <= '0;
      r_rlen    <= '0;
      r_rburst  <= BURST_INCR;
      r_rsz_err <= 1'b0;
      r_rcnt    <= '0;
      r_lat     <= '0;
    end else if (w_ar_hs) begin
      r_rid     <= arid;
      r_roff    <= w_ar_off;
      r_rlen    <= arlen[1:0];
      r_rburst  <= arburst;
      r_rsz_err <= arsize != 3'd2;
      r_rcnt    <= '0;
      r_lat     <= 8'(READ_LAT - 1);
    end else if (r_rs == R_LAT) begin
      r_lat <= r_lat - 8'd1;
    end else if (rvalid && rready) begin
      r_roff <= w_rnext;
      r_rcnt <= r_rcnt + 2'd1;
    end
  end
  assign rid   = r_rid;
  assign rlast = rvalid && r_rcnt == r_rlen;
  assign rdata = (rvalid && !w_roow) ? w_mem_q : 32'd0;
  assign rresp = !rvalid ? RESP_OKAY : w_roow ? RESP_DECERR : r_rsz_err ? RESP_SLVERR : RESP_OKAY;
  assign w_wresp = w_woow ? RESP_DECERR : (r_wsz_err || wlast != (r_wcnt == r_wlen)) ? RESP_SLVERR : RESP_OKAY;
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_bid     <= '0;
      r_woff    <= '0;
      r_wlen    <= '0;
      r_wburst  <= BURST_INCR;
      r_wsz_err <= 1'b0;
      r_wcnt    <= '0;
      r_wait    <= '0;
      r_bresp   <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_bid     <= awid;
      r_woff    <= awaddr - BASE_ADDR;
      r_wlen    <= awlen[1:0];
      r_wburst  <= awburst;
      r_wsz_err <= awsize != 3'd2;
      r_wcnt    <= '0;
      r_wait    <= 8'(WAIT_W);
      r_bresp   <= RESP_OKAY;
    end else begin
      if (r_ws == W_DATA && r_wait != 8'd0) r_wait <= r_wait - 8'd1;
      if (w_w_hs) begin
        r_woff  <= next_off(r_woff, r_wburst);
        r_wcnt  <= r_wcnt + 2'd1;
        r_bresp <= worst_resp(r_bresp, w_wresp);
      end
    end
  end
  assign bid   = r_bid;
  assign bresp = bvalid ? r_bresp : RESP_OKAY;
  axi_slave_mem #(.DEPTH_LOG2(DL)) u_mem (
    .clk    (aclk),
    .i_re   (w_re),
    .i_raddr(w_ridx),
    .o_rdata(w_mem_q),
    .i_we   (w_w_hs && !w_woow),
    .i_waddr(r_woff[DL+1:2]),
    .i_be   (wstrb),
    .i_wdata(wdata)
  );
endmodule
